// File: rtl/clkdiv_arbiter.sv
// Two-requester round-robin arbiter that grants a run of PULSES clko periods at
// the winner's divide ratio. Define CLKDIV_ARB_ABORT_EN to let the owner abort a run.
module clkdiv_arbiter #(
    parameter int DIV_W  = 8,
    parameter int PULSES = 4
) (
    input  logic             clki,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [DIV_W-1:0] div0,
    input  logic [DIV_W-1:0] div1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             clko
);

    localparam int TOG_W = $clog2(2 * PULSES + 1);
    localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(2 * PULSES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] ratio_q, ratio_d;
    logic [TOG_W-1:0] tog_q, tog_d;
    logic             clko_q, clko_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    // last_q = 1 means requester 1 was granted last; it also names the current owner.
    logic             last_q, last_d;

    logic             pick1;
    logic [DIV_W-1:0] sel_div;

    assign pick1   = req1 & (~req0 | ~last_q);
    assign sel_div = pick1 ? div1 : div0;

`ifdef CLKDIV_ARB_ABORT_EN
    logic owner_req;
    assign owner_req = last_q ? req1 : req0;
`endif

    always_ff @(posedge clki or posedge rst) begin
        // NOTE: sequential state is updated with non-blocking assignments only,
        // so every register samples the pre-edge values of the others.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ratio_q <= '0;
            tog_q   <= '0;
            clko_q  <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
            tog_q   <= tog_d;
            clko_q  <= clko_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        // NOTE: every next-state signal is given a default before the case, so no
        // path through this block can leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        ratio_d = ratio_q;
        tog_d   = tog_q;
        clko_d  = clko_q;
        last_d  = last_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;

        case (state_q)
            IDLE: begin
                clko_d = 1'b0;
                if (req0 | req1) begin
                    state_d = RUN;
                    gnt0_d  = ~pick1;
                    gnt1_d  = pick1;
                    last_d  = pick1;
                    ratio_d = (sel_div == '0) ? DIV_W'(1) : sel_div;
                    cnt_d   = '0;
                    tog_d   = '0;
                end
            end

            RUN: begin
                if (cnt_q == ratio_q - DIV_W'(1)) begin
                    cnt_d  = '0;
                    clko_d = ~clko_q;
                    tog_d  = tog_q + TOG_W'(1);
                    if (tog_q == TOG_LAST) begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
`ifdef CLKDIV_ARB_ABORT_EN
                if (!owner_req) begin
                    clko_d  = 1'b0;
                    state_d = DONE;
                end
`endif
            end

            DONE: begin
                state_d = IDLE;
                clko_d  = 1'b0;
                cnt_d   = '0;
                tog_d   = '0;
            end

            default: begin
                state_d = IDLE;
                clko_d  = 1'b0;
            end
        endcase
    end

    assign gnt0 = gnt0_q;
    assign gnt1 = gnt1_q;
    assign clko = clko_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_clkdiv_arbiter.sv
// Randomized and directed bench for clkdiv_arbiter against a run-level reference
// model: a run of 2*PULSES*N cycles whose clko is (elapsed / N) mod 2.
module tb_clkdiv_arbiter;

    localparam int DIV_W  = 8;
    localparam int PULSES = 4;

    logic             clki = 1'b0;
    logic             rst  = 1'b1;
    logic             req0 = 1'b0;
    logic             req1 = 1'b0;
    logic [DIV_W-1:0] div0 = '0;
    logic [DIV_W-1:0] div1 = '0;
    logic             gnt0, gnt1, busy, done, clko;

    clkdiv_arbiter #(.DIV_W(DIV_W), .PULSES(PULSES)) dut (
        .clki (clki),
        .rst  (rst),
        .req0 (req0),
        .req1 (req1),
        .div0 (div0),
        .div1 (div1),
        .gnt0 (gnt0),
        .gnt1 (gnt1),
        .busy (busy),
        .done (done),
        .clko (clko)
    );

    always #5 clki = ~clki;

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 idle, 1 running, 2 done pulse.
    int m_phase, m_k, m_n, m_owner, m_last;
    bit pend0, pend1;
    int gnt_order[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] model_outs();
        logic g0, g1, b, d, c;
        g0 = 1'b0; g1 = 1'b0; b = 1'b0; d = 1'b0; c = 1'b0;
        if (m_phase == 1) begin
            b = 1'b1;
            c = ((m_k / m_n) % 2) == 1;
            if (m_k == 0) begin
                g0 = (m_owner == 0);
                g1 = (m_owner == 1);
            end
        end else if (m_phase == 2) begin
            b = 1'b1;
            d = 1'b1;
        end
        return {g0, g1, b, d, c};
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_k     = 0;
        m_last  = 1;
    endtask

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic model_edge();
        int sel;
        if (rst) begin
            model_reset();
            return;
        end
        case (m_phase)
            0: if (req0 || req1) begin
                m_owner = (req1 && (!req0 || m_last == 0)) ? 1 : 0;
                m_last  = m_owner;
                sel     = (m_owner == 1) ? int'(div1) : int'(div0);
                m_n     = (sel == 0) ? 1 : sel;
                m_k     = 0;
                m_phase = 1;
            end
            1: begin
`ifdef CLKDIV_ARB_ABORT_EN
                if ((m_owner == 0 && !req0) || (m_owner == 1 && !req1)) begin
                    m_phase = 2;
                    return;
                end
`endif
                m_k++;
                if (m_k == 2 * PULSES * m_n) m_phase = 2;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic cyc();
        model_edge();
        @(negedge clki);
        check("outs{g0,g1,busy,done,clko}", 32'({gnt0, gnt1, busy, done, clko}), 32'(model_outs()));
        if (m_phase == 1 && m_k == 0) begin
            if (m_owner == 0) pend0 = 1'b0;
            else              pend1 = 1'b0;
        end
    endtask

    // One cycle plus requester behaviour: the owner releases its request on done.
    task automatic serve();
        cyc();
        if (gnt0) gnt_order.push_back(0);
        if (gnt1) gnt_order.push_back(1);
        if (m_phase == 2) begin
            if (m_owner == 0 && !pend0) req0 = 1'b0;
            if (m_owner == 1 && !pend1) req1 = 1'b0;
        end
    endtask

    task automatic run_until_idle(input int start, output int busy_cnt);
        int n;
        busy_cnt = start;
        n = 0;
        while (n < 200) begin
            serve();
            n++;
            if (busy) busy_cnt++;
            else if (busy_cnt > 0) break;
        end
        if (n >= 200) check("run_timeout", 32'd1, 32'd0);
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1 check("rst_async", 32'({gnt0, gnt1, busy, done, clko}), 32'd0);
        model_reset();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int bc;
        pend0 = 1'b0;
        pend1 = 1'b0;
        model_reset();

        @(negedge clki);
        check("reset_outs", 32'({gnt0, gnt1, busy, done, clko}), 32'd0);
        @(negedge clki);
        check("reset_outs_hold", 32'({gnt0, gnt1, busy, done, clko}), 32'd0);
        rst = 1'b0;
        cyc();

        // Single request, ratio 3: 24 RUN cycles plus the done cycle.
        div0 = 8'd3; req0 = 1'b1; pend0 = 1'b1;
        run_until_idle(0, bc);
        check("single_busy_len", 32'(bc), 32'd25);

        // Tie right after reset: requester 0 wins, then 1, then 0 again.
        rst = 1'b1; cyc(); rst = 1'b0;
        gnt_order.delete();
        div0 = 8'd2; div1 = 8'd5;
        req0 = 1'b1; req1 = 1'b1; pend0 = 1'b1; pend1 = 1'b1;
        run_until_idle(0, bc);
        check("tie_run0_len", 32'(bc), 32'd17);
        run_until_idle(0, bc);
        check("tie_run1_len", 32'(bc), 32'd41);
        req0 = 1'b1; req1 = 1'b1; pend0 = 1'b1; pend1 = 1'b1;
        run_until_idle(0, bc);
        run_until_idle(0, bc);
        check("tie_grants", 32'(gnt_order.size()), 32'd4);
        if (gnt_order.size() == 4) begin
            check("tie_order0", 32'(gnt_order[0]), 32'd0);
            check("tie_order1", 32'(gnt_order[1]), 32'd1);
            check("tie_order2", 32'(gnt_order[2]), 32'd0);
            check("tie_order3", 32'(gnt_order[3]), 32'd1);
        end

        // Zero ratio behaves as 1: 8 RUN cycles.
        div1 = 8'd0; req1 = 1'b1; pend1 = 1'b1;
        run_until_idle(0, bc);
        check("zero_ratio_len", 32'(bc), 32'd9);

        // Ratio change after the grant edge is ignored.
        div0 = 8'd3; req0 = 1'b1; pend0 = 1'b1;
        serve();
        div0 = 8'd7;
        run_until_idle(busy ? 1 : 0, bc);
        check("ratio_change_len", 32'(bc), 32'd25);

        // Reset at RUN cycle 5, request held: re-granted afterwards.
        gnt_order.delete();
        div0 = 8'd3; req0 = 1'b1; pend0 = 1'b1;
        repeat (6) serve();
        async_reset();
        run_until_idle(0, bc);
        check("regrant_len", 32'(bc), 32'd25);
        check("regrant_count", 32'(gnt_order.size()), 32'd2);

        // Owner drops its request at RUN cycle 4.
        div0 = 8'd3; req0 = 1'b1; pend0 = 1'b1;
        serve();
        repeat (3) serve();
        req0 = 1'b0;
        run_until_idle(4, bc);
`ifdef CLKDIV_ARB_ABORT_EN
        check("drop_len", 32'(bc), 32'd5);
`else
        check("drop_len", 32'(bc), 32'd25);
`endif

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            div0 = DIV_W'($urandom_range(0, 4));
            div1 = DIV_W'($urandom_range(0, 4));
            if (!req0 && $urandom_range(0, 3) == 0) begin req0 = 1'b1; pend0 = 1'b1; end
            if (!req1 && $urandom_range(0, 3) == 0) begin req1 = 1'b1; pend1 = 1'b1; end
            if (m_phase == 1 && $urandom_range(0, 15) == 0) begin
                if (m_owner == 0 && !pend0) req0 = 1'b0;
                if (m_owner == 1 && !pend1) req1 = 1'b0;
            end
            if ($urandom_range(0, 249) == 0) async_reset();
            else serve();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
